// File: rtl/aes128_dec_iter.sv
// rtl/aes128_dec_iter.sv - iterative AES-128 inverse cipher with on-chip cached key schedule
// LANES=16 runs one round per cycle; LANES=4 runs one column of InvSubBytes per cycle.
module aes128_dec_iter #(
  parameter int LANES = 16
) (
  input  logic         clk,
  input  logic         decReset,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         key_loaded,
  output logic         busy
);

  typedef enum logic [2:0] {NOKEY, KEXP, IDLE, ROUND, DONE} state_t;

  state_t               state, state_next;
  logic [10:0][127:0]   rk;
  logic [127:0]         st, out_r, rk_cur, round_out, kexp_prev, kexp_next;
  logic [3:0]           rnd, kcnt;
  logic [1:0]           sub;
  logic                 key_fire, in_fire, step_end, key_loaded_r;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 via an addition chain; 0 maps to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = ginv(x);
    return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] v;
    case (i)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Byte index row+4*col sits at bits [127-8*index -: 8].
  function automatic logic [127:0] isr(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*((c+w)%4)) -: 8] = s[127-8*(w+4*c) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] imix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] p, input logic [7:0] rc);
    logic [31:0]  w3, tw;
    logic [127:0] n;
    w3 = p[31:0];
    tw = {fwd_sbox(w3[23:16]), fwd_sbox(w3[15:8]), fwd_sbox(w3[7:0]), fwd_sbox(w3[31:24])}
         ^ {rc, 24'h000000};
    n[127:96] = p[127:96] ^ tw;
    n[95:64]  = p[95:64]  ^ n[127:96];
    n[63:32]  = p[63:32]  ^ n[95:64];
    n[31:0]   = p[31:0]   ^ n[63:32];
    return n;
  endfunction

  assign key_fire   = key_valid & key_ready;
  assign in_fire    = in_valid & in_ready;
  assign step_end   = (LANES == 16) || (sub == 2'd3);
  assign out        = out_r;
  assign out_valid  = (state == DONE);
  assign busy       = (state == KEXP) || (state == ROUND);
  assign key_loaded = key_loaded_r;

  always_ff @(posedge clk or posedge decReset) begin
    if (decReset) state <= NOKEY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    in_ready   = 1'b0;
    case (state)
      NOKEY: begin
        key_ready = 1'b1;
        if (key_valid) state_next = KEXP;
      end
      KEXP: if (kcnt == 4'd10) state_next = IDLE;
      IDLE: begin
        key_ready = 1'b1;
        in_ready  = !key_valid;
        if (key_valid)     state_next = KEXP;
        else if (in_valid) state_next = ROUND;
      end
      ROUND: if (step_end && rnd == 4'd0) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = NOKEY;
    endcase
  end

  always_comb begin
    kexp_prev = rk[0];
    for (int i = 1; i <= 10; i++)
      if (kcnt == i[3:0]) kexp_prev = rk[i-1];
    kexp_next = expand(kexp_prev, rcon(kcnt));
  end

  always_comb begin
    rk_cur = rk[0];
    for (int i = 1; i < 10; i++)
      if (rnd == i[3:0]) rk_cur = rk[i];
  end

  generate
    if (LANES == 16) begin : g_full
      logic [127:0] t;
      always_comb begin
        t = isr(st);
        for (int i = 0; i < 16; i++) t[127-8*i -: 8] = inv_sbox(t[127-8*i -: 8]);
        t = t ^ rk_cur;
        round_out = (rnd == 4'd0) ? t : imix(t);
      end
    end else if (LANES == 4) begin : g_col
      logic [127:0] t, k;
      logic [31:0]  col, scol;
      // Only the selected column passes through the four S-boxes each sub-cycle.
      always_comb begin
        t   = (sub == 2'd0) ? isr(st) : st;
        col = '0;
        for (int c = 0; c < 4; c++)
          if (sub == c[1:0]) col = t[127-32*c -: 32];
        scol = '0;
        for (int j = 0; j < 4; j++) scol[31-8*j -: 8] = inv_sbox(col[31-8*j -: 8]);
        for (int c = 0; c < 4; c++)
          if (sub == c[1:0]) t[127-32*c -: 32] = scol;
        k = t ^ rk_cur;
        round_out = t;
        if (sub == 2'd3) round_out = (rnd == 4'd0) ? k : imix(k);
      end
    end else begin : g_bad
      $error("aes128_dec_iter: LANES must be 16 or 4");
    end
  endgenerate

  always_ff @(posedge clk or posedge decReset) begin
    if (decReset) begin
      rk           <= '0;
      st           <= '0;
      out_r        <= '0;
      rnd          <= '0;
      sub          <= '0;
      kcnt         <= '0;
      key_loaded_r <= 1'b0;
    end else begin
      case (state)
        NOKEY, IDLE: begin
          if (key_fire) begin
            rk[0]        <= key;
            kcnt         <= 4'd1;
            key_loaded_r <= 1'b0;
          end else if (in_fire) begin
            st  <= in ^ rk[10];
            rnd <= 4'd9;
            sub <= 2'd0;
          end
        end
        KEXP: begin
          for (int i = 1; i <= 10; i++)
            if (kcnt == i[3:0]) rk[i] <= kexp_next;
          kcnt <= kcnt + 4'd1;
          if (kcnt == 4'd10) key_loaded_r <= 1'b1;
        end
        ROUND: begin
          if (step_end && rnd == 4'd0) out_r <= round_out;
          else                         st    <= round_out;
          if (step_end) rnd <= rnd - 4'd1;
          sub <= sub + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_dec_iter.sv
// tb/tb_aes128_dec_iter.sv - directed bench for aes128_dec_iter with a table-driven AES model
// The model builds its S-boxes from log/antilog tables and checks every meaningful output cycle.
module tb_aes128_dec_iter;
  localparam int LANES = 16;
  localparam int LAT   = (LANES == 16) ? 10 : 40;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         decReset = 1'b1;
  logic [127:0] key = '0, din = '0;
  logic         key_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         key_ready, in_ready, out_valid, key_loaded, busy;
  logic [127:0] dout;

  int errors = 0;
  int checks = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t[256];
  logic [7:0] alog   [256];
  int         lg     [256];

  aes128_dec_iter #(.LANES(LANES)) dut (
    .clk(clk), .decReset(decReset),
    .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .out(dout), .out_valid(out_valid), .out_ready(out_ready),
    .key_loaded(key_loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required a finished run");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime8(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return alog[(lg[a] + lg[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] p, inv, s, c;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = p;
      lg[p]   = i;
      p = p ^ xtime8(p);
    end
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x]  = s;
      isbox_t[s] = x[7:0];
    end
  endtask

  function automatic logic [127:0] m_dec(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   u [4][4];
    logic [7:0]   a [4];
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime8(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = ct[127-8*(r+4*c) -: 8] ^ w[40+c][31-8*r -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          u[r][(c+r)%4] = isbox_t[s[r][c]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = u[r][c] ^ w[4*rd+c][31-8*r -: 8];
      if (rd > 0)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[r][c];
          for (int r = 0; r < 4; r++)
            s[r][c] = gm(8'h0e, a[r]) ^ gm(8'h0b, a[(r+1)%4]) ^ gm(8'h0d, a[(r+2)%4]) ^ gm(8'h09, a[(r+3)%4]);
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  // Scoreboard: expected plaintexts queued at each block handshake.
  logic [127:0] exp_q[$];
  logic [127:0] model_key = '0;
  logic [127:0] hold = '0;

  always @(negedge clk) begin
    if (decReset) begin
      exp_q.delete();
      hold = '0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_valid_spurious", 128'(out_valid), 128'(0));
        else begin
          chk("out_vs_model", dout, exp_q[0]);
          hold = exp_q[0];
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("out_hold", dout, hold);
      end
      if (key_valid && key_ready) model_key = key;
      if (in_valid && in_ready) exp_q.push_back(m_dec(din, model_key));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input string nm);
    int n;
    key = k;
    key_valid = 1'b1;
    #1;
    n = 0;
    while (!key_ready && n < 100) begin tick(); n++; end
    chk({nm, "_key_accept"}, 128'(key_ready), 128'(1));
    tick();
    key_valid = 1'b0;
    chk({nm, "_busy_kexp"}, 128'(busy), 128'(1));
    n = 0;
    while (!key_loaded && n < 100) begin n++; tick(); end
    chk({nm, "_key_loaded_low_cycles"}, 128'(n), 128'(10));
  endtask

  task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp, input string nm, input bit take);
    int n;
    din = ct;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk({nm, "_in_accept"}, 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk({nm, "_latency"}, 128'(n), 128'(LAT));
    chk({nm, "_plaintext"}, dout, exp);
    if (take) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, "_out_valid_drop"}, 128'(out_valid), 128'(0));
      chk({nm, "_in_ready_back"}, 128'(in_ready), 128'(1));
    end
  endtask

  initial begin
    int n;
    logic [127:0] ct;
    build_tables();
    chk("model_sbox_00", 128'(sbox_t[0]), 128'h63);
    chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    chk("model_isbox_00", 128'(isbox_t[0]), 128'h52);
    chk("model_c1", m_dec(C1_CT, C1_KEY), C1_PT);
    chk("model_appb", m_dec(B_CT, B_KEY), B_PT);

    repeat (2) tick();
    chk("rst_out", dout, 128'h0);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_key_loaded", 128'(key_loaded), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    decReset = 1'b0;
    #1;
    chk("nokey_key_ready", 128'(key_ready), 128'(1));

    din = C1_CT;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("nokey_in_refused", 128'(in_ready), 128'(0));
      tick();
    end
    in_valid = 1'b0;

    load_key(C1_KEY, "c1");
    decrypt(C1_CT, C1_PT, "c1", 1'b1);

    load_key(B_KEY, "appb");
    decrypt(B_CT, B_PT, "appb", 1'b1);
    decrypt(B_CT, B_PT, "appb_again", 1'b1);
    chk("appb_again_key_loaded", 128'(key_loaded), 128'(1));
    for (int i = 0; i < 3; i++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      decrypt(ct, m_dec(ct, B_KEY), "rand", 1'b1);
    end

    decrypt(B_CT, B_PT, "bp", 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_out_stable", dout, B_PT);
      chk("bp_out_valid_held", 128'(out_valid), 128'(1));
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_out_valid_drop", 128'(out_valid), 128'(0));
    chk("bp_in_ready_back", 128'(in_ready), 128'(1));

    load_key(C1_KEY, "keychg");
    decrypt(C1_CT, C1_PT, "keychg", 1'b1);

    key = C1_KEY;
    key_valid = 1'b1;
    din = C1_CT;
    in_valid = 1'b1;
    #1;
    chk("prio_in_ready_low", 128'(in_ready), 128'(0));
    chk("prio_key_ready", 128'(key_ready), 128'(1));
    tick();
    key_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin n++; tick(); end
    chk("prio_block_wait_cycles", 128'(n), 128'(10));
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk("prio_latency", 128'(n), 128'(LAT));
    chk("prio_plaintext", dout, C1_PT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    din = B_CT;
    in_valid = 1'b1;
    #1 chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("mid_rst_busy_before", 128'(busy), 128'(1));
    decReset = 1'b1;
    #1;
    chk("mid_rst_out", dout, 128'h0);
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_key_loaded", 128'(key_loaded), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    tick();
    decReset = 1'b0;
    #1 chk("mid_rst_key_ready", 128'(key_ready), 128'(1));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mid_rst_block_refused", 128'(in_ready), 128'(0));
      tick();
    end
    in_valid = 1'b0;
    load_key(C1_KEY, "reload");
    decrypt(C1_CT, C1_PT, "reload", 1'b1);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
